// File: rtl/rfaludm_ctrl_fsm.sv
// Multi-cycle control sequencer for the RF/ALU/DM datapath.
// Accepts one instruction per valid/ready handshake, latches it in IR and steps the
// datapath controls through DECODE, EXEC, MEM and WB for R-type, lw, sw and beq.
// Optional feature macro: RFALUDM_MEM_WAIT_EN stretches MEM to MEM_WAIT+1 cycles.
module rfaludm_ctrl_fsm #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic             Zero,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [15:0]      SEin,
  output logic [1:0]       ALUop,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             branch_taken,
  output logic             illegal_op,
  output logic             done,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic [2:0] {StIdle, StDecode, StExec, StMem, StWb} state_e;

  localparam logic [5:0] OpR   = 6'h00;
  localparam logic [5:0] OpLw  = 6'h23;
  localparam logic [5:0] OpSw  = 6'h2B;
  localparam logic [5:0] OpBeq = 6'h04;

  // Catch nonsensical configurations at elaboration time.
  if (CNT_W == 0 || MEM_WAIT > 65535) begin : g_param_err
    $error("rfaludm_ctrl_fsm: CNT_W must be nonzero and MEM_WAIT below 65536");
  end

  state_e             state_q, state_d;
  logic [31:0]        ir_q, ir_d;
  logic [CNT_W-1:0]   retire_q, retire_d;
  logic               mem_last;

  logic [5:0] op;
  logic       is_r, is_lw, is_sw, is_beq, is_legal;

  assign op       = ir_q[31:26];
  assign is_r     = (op == OpR);
  assign is_lw    = (op == OpLw);
  assign is_sw    = (op == OpSw);
  assign is_beq   = (op == OpBeq);
  assign is_legal = is_r | is_lw | is_sw | is_beq;

`ifdef RFALUDM_MEM_WAIT_EN
  localparam int unsigned WaitW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  logic [WaitW-1:0] wait_q, wait_d;
  assign mem_last = (wait_q == '0);
`else
  assign mem_last = 1'b1;
`endif

  // Next-state, IR load, wait counter and retire counter.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    retire_d = done ? retire_q + CNT_W'(1) : retire_q;
`ifdef RFALUDM_MEM_WAIT_EN
    wait_d   = wait_q;
`endif
    case (state_q)
      StIdle: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = StDecode;
        end
      end
      StDecode: state_d = is_legal ? StExec : StIdle;
      StExec: begin
        if (is_beq) begin
          state_d = StIdle;
        end else if (is_r) begin
          state_d = StWb;
        end else begin
          state_d = StMem;
`ifdef RFALUDM_MEM_WAIT_EN
          wait_d  = WaitW'(MEM_WAIT);
`endif
        end
      end
      StMem: begin
        if (mem_last) begin
          state_d = is_lw ? StWb : StIdle;
        end
`ifdef RFALUDM_MEM_WAIT_EN
        else begin
          wait_d = wait_q - 1'b1;
        end
`endif
      end
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      ir_q     <= '0;
      retire_q <= '0;
`ifdef RFALUDM_MEM_WAIT_EN
      wait_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      retire_q <= retire_d;
`ifdef RFALUDM_MEM_WAIT_EN
      wait_q   <= wait_d;
`endif
    end
  end

  // Datapath controls decoded from state and IR; everything forced low while reset is high.
  always_comb begin
    instr_ready  = 1'b0;
    rs           = '0;
    rt           = '0;
    rd           = '0;
    SEin         = '0;
    ALUop        = 2'b00;
    RegDst       = 1'b0;
    ALUSrc       = 1'b0;
    MemtoReg     = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    RegWrite     = 1'b0;
    branch_taken = 1'b0;
    illegal_op   = 1'b0;
    done         = 1'b0;
    retire_count = '0;
    if (!reset) begin
      rs           = ir_q[25:21];
      rt           = ir_q[20:16];
      rd           = ir_q[15:11];
      SEin         = ir_q[15:0];
      retire_count = retire_q;
      // ALUop/ALUSrc hold from EXEC to the end so DM address and WB data stay stable.
      if (state_q == StExec || state_q == StMem || state_q == StWb) begin
        ALUop  = is_r ? 2'b10 : (is_beq ? 2'b01 : 2'b00);
        ALUSrc = is_lw | is_sw;
      end
      case (state_q)
        StIdle:   instr_ready = 1'b1;
        StDecode: illegal_op  = ~is_legal;
        StExec: begin
          if (is_beq) begin
            branch_taken = Zero;
            done         = 1'b1;
          end
        end
        StMem: begin
          MemRead  = is_lw;
          MemWrite = is_sw & mem_last;
          done     = is_sw & mem_last;
        end
        StWb: begin
          RegWrite = 1'b1;
          RegDst   = is_r;
          MemtoReg = is_lw;
          MemRead  = is_lw;
          done     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rfaludm_ctrl_fsm.sv
// Directed, table-driven bench for rfaludm_ctrl_fsm (default build, MEM wait disabled).
// A second instance with CNT_W=2 shares the stimulus to check counter wrap.
module tb_rfaludm_ctrl_fsm;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        Zero;

  logic        instr_ready, RegDst, ALUSrc, MemtoReg, MemRead, MemWrite, RegWrite;
  logic        branch_taken, illegal_op, done;
  logic [4:0]  rs, rt, rd;
  logic [15:0] SEin;
  logic [1:0]  ALUop;
  logic [15:0] retire_count;

  logic        w_ready, w_regdst, w_alusrc, w_memtoreg, w_memread, w_memwrite, w_regwrite;
  logic        w_bt, w_ill, w_done;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_sein;
  logic [1:0]  w_aluop;
  logic [1:0]  w_retire;

  always #5 clock = ~clock;

  rfaludm_ctrl_fsm #(.CNT_W(16), .MEM_WAIT(2)) u_dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .Zero(Zero), .rs(rs), .rt(rt), .rd(rd), .SEin(SEin), .ALUop(ALUop),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .branch_taken(branch_taken),
    .illegal_op(illegal_op), .done(done), .retire_count(retire_count)
  );

  rfaludm_ctrl_fsm #(.CNT_W(2), .MEM_WAIT(2)) u_dut_wrap (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(w_ready),
    .instr(instr), .Zero(Zero), .rs(w_rs), .rt(w_rt), .rd(w_rd), .SEin(w_sein),
    .ALUop(w_aluop), .RegDst(w_regdst), .ALUSrc(w_alusrc), .MemtoReg(w_memtoreg),
    .MemRead(w_memread), .MemWrite(w_memwrite), .RegWrite(w_regwrite),
    .branch_taken(w_bt), .illegal_op(w_ill), .done(w_done), .retire_count(w_retire)
  );

  localparam logic [31:0] IR_R   = 32'h00851020;
  localparam logic [31:0] IR_LW  = 32'h8C880004;
  localparam logic [31:0] IR_SW  = 32'hAC880008;
  localparam logic [31:0] IR_BEQ = 32'h10850003;
  localparam logic [31:0] IR_ILL = 32'hFC000000;

  // ctl = {RegDst, ALUSrc, MemtoReg, MemRead, MemWrite, RegWrite}
  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] ins;
    logic        zero;
    logic        rdy;
    logic [1:0]  aluop;
    logic [5:0]  ctl;
    logic        bt;
    logic        ill;
    logic        dn;
    logic [15:0] rc;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int idx, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic vld, input logic [31:0] ins,
                              input logic zero, input logic rdy, input logic [1:0] aluop,
                              input logic [5:0] ctl, input logic bt, input logic ill,
                              input logic dn, input logic [15:0] rc);
    vec_t v;
    v.rst = rst; v.vld = vld; v.ins = ins; v.zero = zero; v.rdy = rdy; v.aluop = aluop;
    v.ctl = ctl; v.bt = bt; v.ill = ill; v.dn = dn; v.rc = rc;
    return v;
  endfunction

  logic [63:0] got_v, exp_v;

  initial begin
    //               rst vld ins     z  rdy aluop ctl        bt ill dn rc
    vecs[0]  = mk(1, 0, 32'h0,  0, 0, 2'b00, 6'b000000, 0, 0, 0, 0); // reset
    vecs[1]  = mk(1, 0, 32'h0,  0, 0, 2'b00, 6'b000000, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, IR_R,   1, 0, 2'b00, 6'b000000, 0, 0, 0, 0); // gated in reset
    vecs[3]  = mk(0, 0, 32'h0,  0, 1, 2'b00, 6'b000000, 0, 0, 0, 0); // idle
    vecs[4]  = mk(0, 1, IR_R,   0, 1, 2'b00, 6'b000000, 0, 0, 0, 0); // accept R
    vecs[5]  = mk(0, 0, 32'h0,  0, 0, 2'b00, 6'b000000, 0, 0, 0, 0); // DECODE
    vecs[6]  = mk(0, 0, 32'h0,  0, 0, 2'b10, 6'b000000, 0, 0, 0, 0); // EXEC
    vecs[7]  = mk(0, 0, 32'h0,  0, 0, 2'b10, 6'b100001, 0, 0, 1, 0); // WB
    vecs[8]  = mk(0, 1, IR_LW,  0, 1, 2'b00, 6'b000000, 0, 0, 0, 1); // accept lw
    vecs[9]  = mk(0, 0, 32'h0,  0, 0, 2'b00, 6'b000000, 0, 0, 0, 1);
    vecs[10] = mk(0, 0, 32'h0,  0, 0, 2'b00, 6'b010000, 0, 0, 0, 1); // EXEC
    vecs[11] = mk(0, 0, 32'h0,  0, 0, 2'b00, 6'b010100, 0, 0, 0, 1); // MEM read
    vecs[12] = mk(0, 0, 32'h0,  0, 0, 2'b00, 6'b011101, 0, 0, 1, 1); // WB
    vecs[13] = mk(0, 1, IR_SW,  0, 1, 2'b00, 6'b000000, 0, 0, 0, 2); // accept sw
    vecs[14] = mk(0, 0, 32'h0,  0, 0, 2'b00, 6'b000000, 0, 0, 0, 2);
    vecs[15] = mk(0, 0, 32'h0,  0, 0, 2'b00, 6'b010000, 0, 0, 0, 2);
    vecs[16] = mk(0, 0, 32'h0,  0, 0, 2'b00, 6'b010010, 0, 0, 1, 2); // MEM write
    vecs[17] = mk(0, 1, IR_BEQ, 1, 1, 2'b00, 6'b000000, 0, 0, 0, 3); // beq, Zero=1
    vecs[18] = mk(0, 0, 32'h0,  1, 0, 2'b00, 6'b000000, 0, 0, 0, 3);
    vecs[19] = mk(0, 0, 32'h0,  1, 0, 2'b01, 6'b000000, 1, 0, 1, 3); // taken
    vecs[20] = mk(0, 1, IR_BEQ, 0, 1, 2'b00, 6'b000000, 0, 0, 0, 4); // beq, Zero=0
    vecs[21] = mk(0, 1, IR_R,   0, 0, 2'b00, 6'b000000, 0, 0, 0, 4); // valid while busy
    vecs[22] = mk(0, 1, IR_R,   0, 0, 2'b01, 6'b000000, 0, 0, 1, 4); // not taken
    vecs[23] = mk(0, 1, IR_ILL, 0, 1, 2'b00, 6'b000000, 0, 0, 0, 5); // accept illegal
    vecs[24] = mk(0, 0, 32'h0,  0, 0, 2'b00, 6'b000000, 0, 1, 0, 5); // illegal pulse
    vecs[25] = mk(0, 1, IR_SW,  0, 1, 2'b00, 6'b000000, 0, 0, 0, 5); // accept sw
    vecs[26] = mk(0, 0, 32'h0,  0, 0, 2'b00, 6'b000000, 0, 0, 0, 5);
    vecs[27] = mk(0, 0, 32'h0,  0, 0, 2'b00, 6'b010000, 0, 0, 0, 5);
    vecs[28] = mk(1, 0, 32'h0,  0, 0, 2'b00, 6'b000000, 0, 0, 0, 0); // reset in MEM
    vecs[29] = mk(0, 0, 32'h0,  0, 1, 2'b00, 6'b000000, 0, 0, 0, 0);
    vecs[30] = mk(0, 0, 32'h0,  0, 1, 2'b00, 6'b000000, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      reset       = vecs[i].rst;
      instr_valid = vecs[i].vld;
      instr       = vecs[i].ins;
      Zero        = vecs[i].zero;
      @(negedge clock);
      got_v = {33'd0, instr_ready, ALUop, RegDst, ALUSrc, MemtoReg, MemRead, MemWrite,
               RegWrite, branch_taken, illegal_op, done, retire_count};
      exp_v = {33'd0, vecs[i].rdy, vecs[i].aluop, vecs[i].ctl, vecs[i].bt, vecs[i].ill,
               vecs[i].dn, vecs[i].rc};
      check("vec", i, got_v, exp_v);
      check("wrap_cnt", i, {62'd0, w_retire}, {62'd0, vecs[i].rc[1:0]});
      @(posedge clock);
      #1;
    end

    // Field extraction from IR, then reset gating of the same fields.
    reset = 1'b0; instr_valid = 1'b1; instr = IR_R; Zero = 1'b0;
    @(posedge clock); #1;
    instr_valid = 1'b0;
    @(negedge clock);
    check("fields", 0, {43'd0, rs, rt, rd, SEin}, {43'd0, 5'd4, 5'd5, 5'd2, 16'h1020});
    reset = 1'b1;
    @(negedge clock);
    check("fields_rst", 0, {43'd0, instr_ready, rs, rt, rd, SEin}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("idle_after_rst", 0, {62'd0, instr_ready, done}, {62'd0, 1'b1, 1'b0});

    // lw field check in DECODE, then bounded wait for its done pulse.
    instr_valid = 1'b1; instr = IR_LW;
    @(posedge clock); #1;
    instr_valid = 1'b0;
    @(negedge clock);
    check("lw_fields", 0, {43'd0, rs, rt, rd, SEin}, {43'd0, 5'd4, 5'd8, 5'd0, 16'h0004});
    begin
      int cyc = 0;
      while (!done && cyc < 20) begin
        @(posedge clock); #1;
        @(negedge clock);
        cyc++;
      end
      // DECODE seen at cycle 0, done expected in WB three cycles later.
      check("lw_done_cycle", 0, 64'(cyc), 64'd3);
    end
    @(posedge clock); #1;
    @(negedge clock);
    check("lw_retired", 0, {48'd0, retire_count}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
